// File: rtl/s_u_seqdiv8.sv
// rtl/s_u_seqdiv8.sv - sequential unsigned restoring divider, 2N/N bits, one quotient bit per cycle
// Low K dividend bits may be truncated so products from the truncated multipliers can be divided back.
module s_u_seqdiv8 #(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*N-1:0] am;
  logic [N-1:0]   pr;
  logic [N-1:0]   qr;
  logic [N-1:0]   br;
  logic [CW-1:0]  cnt;
  logic [N:0]     t;
  logic [N-1:0]   diff;
  logic           t_ge;
  logic           last;
  logic           special;

  assign am = (a >> K) << K;

  // PR < b holds at every iteration start, so PR fits N bits and T - b fits N bits.
  assign t       = {pr, qr[N-1]};
  assign t_ge    = (t >= {1'b0, br});
  assign diff    = t[N-1:0] - br;
  assign last    = (cnt == CW'(N - 1));
  assign special = (b == '0) || (am[2*N-1:N] >= b);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pr    <= '0;
      qr    <= '0;
      br    <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (b == '0) begin
              dbz <= 1'b1;
              ovf <= 1'b0;
              q   <= '1;
              r   <= am[N-1:0];
            end else if (am[2*N-1:N] >= b) begin
              dbz <= 1'b0;
              ovf <= 1'b1;
              q   <= '1;
              r   <= am[N-1:0];
            end else begin
              pr  <= am[2*N-1:N];
              qr  <= am[N-1:0];
              br  <= b;
              cnt <= '0;
              ovf <= 1'b0;
              dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          pr  <= t_ge ? diff : t[N-1:0];
          qr  <= {qr[N-2:0], t_ge};
          cnt <= cnt + 1'b1;
          if (last) begin
            q <= {qr[N-2:0], t_ge};
            r <= t_ge ? diff : t[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s_u_seqdiv8.sv
// tb/tb_s_u_seqdiv8.sv - directed and random checks of s_u_seqdiv8 (K=0 and K=4 instances)
module tb_s_u_seqdiv8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [7:0]  b;
  logic        out_ready;

  logic       in_ready0, out_valid0, ovf0, dbz0;
  logic [7:0] q0, r0;
  logic       in_ready4, out_valid4, ovf4, dbz4;
  logic [7:0] q4, r4;

  int checks;
  int errors;

  s_u_seqdiv8 #(.N(8), .K(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .q(q0), .r(r0), .ovf(ovf0), .dbz(dbz0)
  );

  s_u_seqdiv8 #(.N(8), .K(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .q(q4), .r(r4), .ovf(ovf4), .dbz(dbz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one operand pair; lat counts edges with the accept edge as 1.
  task automatic do_op(input logic [15:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid0 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int          lat;
  int          seen;
  logic [15:0] av;
  logic [7:0]  bv;
  logic [15:0] qq;
  logic [7:0]  eq, er;
  logic        eo, ed;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_q", q0, 0);
    chk("rst_r", r0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_dbz", dbz0, 0);

    // max product divided back
    do_op(16'hFE01, 8'hFF, lat);
    chk("max_lat", lat, 9);
    chk("max_q", q0, 8'hFF);
    chk("max_r", r0, 8'h00);
    chk("max_ovf", ovf0, 0);
    chk("max_dbz", dbz0, 0);
    release_out();
    chk("max_out_valid_clr", out_valid0, 0);
    chk("max_in_ready", in_ready0, 1);

    // 1000 / 7 with back-pressure
    do_op(16'h03E8, 8'h07, lat);
    chk("gen_lat", lat, 9);
    chk("gen_q", q0, 8'h8E);
    chk("gen_r", r0, 8'h06);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid0, 1);
      chk("hold_q", q0, 8'h8E);
      chk("hold_r", r0, 8'h06);
    end
    release_out();
    chk("gen_in_ready", in_ready0, 1);
    chk("gen_out_valid_clr", out_valid0, 0);

    // operands offered while busy are ignored
    @(negedge clk);
    a = 16'h03E8;
    b = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'h1234;
      b = 8'h00;
      chk("busy_in_ready", in_ready0, 0);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_valid", out_valid0, 1);
    chk("busy_q", q0, 8'h8E);
    chk("busy_r", r0, 8'h06);
    chk("busy_dbz", dbz0, 0);
    release_out();

    // overflow
    do_op(16'h1234, 8'h12, lat);
    chk("ovf_lat", lat, 1);
    chk("ovf_flag", ovf0, 1);
    chk("ovf_dbz", dbz0, 0);
    chk("ovf_q", q0, 8'hFF);
    chk("ovf_r", r0, 8'h34);
    release_out();

    // divide by zero
    do_op(16'h1234, 8'h00, lat);
    chk("dbz_lat", lat, 1);
    chk("dbz_flag", dbz0, 1);
    chk("dbz_ovf", ovf0, 0);
    chk("dbz_q", q0, 8'hFF);
    chk("dbz_r", r0, 8'h34);
    release_out();

    // truncation: K=4 sees 992, K=0 sees 1007
    do_op(16'h03EF, 8'h07, lat);
    chk("trunc_lat", lat, 9);
    chk("trunc_valid4", out_valid4, 1);
    chk("trunc_q4", q4, 8'h8D);
    chk("trunc_r4", r4, 8'h05);
    chk("trunc_ovf4", ovf4, 0);
    chk("trunc_q0", q0, 8'h8F);
    chk("trunc_r0", r0, 8'h06);
    release_out();

    // reset in the middle of CALC
    @(negedge clk);
    a = 16'h03E8;
    b = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_q", q0, 0);
    chk("abort_r", r0, 0);
    chk("abort_in_ready", in_ready0, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid0) seen++;
    end
    chk("abort_no_result", seen, 0);
    do_op(16'h0064, 8'h0A, lat);
    chk("post_lat", lat, 9);
    chk("post_q", q0, 8'h0A);
    chk("post_r", r0, 8'h00);
    release_out();

    // random operands with random back-pressure
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) bv = 8'h00;
      else bv = 8'($urandom_range(1, 255));
      av = 16'($urandom);
      if (bv != 0 && $urandom_range(0, 3) != 0) av[15:8] = 8'($urandom_range(0, int'(bv) - 1));
      if (bv == 0) begin
        eq = 8'hFF; er = av[7:0]; eo = 1'b0; ed = 1'b1;
      end else if (av[15:8] >= bv) begin
        eq = 8'hFF; er = av[7:0]; eo = 1'b1; ed = 1'b0;
      end else begin
        qq = av / {8'h00, bv};
        eq = qq[7:0];
        qq = av % {8'h00, bv};
        er = qq[7:0];
        eo = 1'b0; ed = 1'b0;
      end
      do_op(av, bv, lat);
      chk("rnd_valid", out_valid0, 1);
      chk("rnd_lat", lat, (eo || ed) ? 1 : 9);
      chk("rnd_q", q0, eq);
      chk("rnd_r", r0, er);
      chk("rnd_ovf", ovf0, eo);
      chk("rnd_dbz", dbz0, ed);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rnd_still_valid", out_valid0, 1);
      release_out();
      chk("rnd_consumed", out_valid0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
